// File: rtl/color_detect_pkg.sv
// Shared types and widths for the hue colour-detection stages.
package color_detect_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned HUE_MAX = 360;
    localparam int unsigned HUE_W   = 9;
    localparam int unsigned COORD_W = 10;
    localparam int unsigned COUNT_W = 20;

    typedef enum logic [0:0] {
        SYNC   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    typedef struct packed {
        logic [COORD_W-1:0] xmin;
        logic [COORD_W-1:0] xmax;
        logic [COORD_W-1:0] ymin;
        logic [COORD_W-1:0] ymax;
    } bbox_t;

endpackage

// File: rtl/hue_window_cmp.sv
// Combinational hue window test; a low bound above the high bound wraps through 0.
module hue_window_cmp
    import color_detect_pkg::*;
(
    input  logic [DATA_W-1:0] i_h,
    input  logic [HUE_W-1:0]  i_lo,
    input  logic [HUE_W-1:0]  i_hi,
    output logic              o_match_c
);

    logic [DATA_W-1:0] lo_w;
    logic [DATA_W-1:0] hi_w;
    logic              in_window;

    always_comb begin
        lo_w = DATA_W'(i_lo);
        hi_w = DATA_W'(i_hi);
        if (i_lo <= i_hi) begin
            in_window = (i_h >= lo_w) && (i_h <= hi_w);
        end else begin
            in_window = (i_h >= lo_w) || (i_h <= hi_w);
        end
        o_match_c = in_window && (i_h < DATA_W'(HUE_MAX));
    end

endmodule

// File: rtl/hue_bbox_tracker.sv
// Per-pixel hue mask plus per-frame matching-pixel count and bounding box.
module hue_bbox_tracker
    import color_detect_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned MIN_PIXELS = 64
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [DATA_W-1:0]  i_data,
    input  logic               i_valid,
    input  logic               i_sof,
    input  logic [HUE_W-1:0]   i_hue_lo,
    input  logic [HUE_W-1:0]   i_hue_hi,
    output logic               o_mask,
    output logic               o_mask_valid,
    output logic [COORD_W-1:0] o_xmin,
    output logic [COORD_W-1:0] o_xmax,
    output logic [COORD_W-1:0] o_ymin,
    output logic [COORD_W-1:0] o_ymax,
    output logic [COUNT_W-1:0] o_count,
    output logic               o_found,
    output logic               o_bbox_valid,
    output logic               o_err
);

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_ACTIVE - 1);

    state_e             state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [COUNT_W-1:0] acc_cnt_q, acc_cnt_d;
    bbox_t              acc_box_q, acc_box_d;
    logic               acc_hit_q, acc_hit_d;
    logic [HUE_W-1:0]   lo_q, lo_d, hi_q, hi_d;
    logic               mask_q, mask_d, mask_vld_q, mask_vld_d;
    logic               err_q, err_d, bbox_vld_q, bbox_vld_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic               found_q, found_d;
    bbox_t              box_q, box_d;

    logic [HUE_W-1:0]   win_lo, win_hi;
    logic               match;
    logic               proc, start, last_px;
    logic [COORD_W-1:0] cx, cy;
    logic [COUNT_W-1:0] n_cnt;
    bbox_t              n_box;
    logic               n_hit;

    // A sof pixel is classified against the window presented with it.
    assign win_lo = i_sof ? i_hue_lo : lo_q;
    assign win_hi = i_sof ? i_hue_hi : hi_q;

    hue_window_cmp u_cmp (
        .i_h       (i_data),
        .i_lo      (win_lo),
        .i_hi      (win_hi),
        .o_match_c (match)
    );

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        acc_cnt_d  = acc_cnt_q;
        acc_box_d  = acc_box_q;
        acc_hit_d  = acc_hit_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        cnt_d      = cnt_q;
        found_d    = found_q;
        box_d      = box_q;
        mask_d     = 1'b0;
        mask_vld_d = i_valid;
        err_d      = 1'b0;
        bbox_vld_d = 1'b0;
        proc       = 1'b0;
        start      = 1'b0;

        // ACTIVE at (0,0) only occurs right after a completed frame.
        if (i_valid) begin
            if (i_sof) begin
                start   = 1'b1;
                proc    = 1'b1;
                err_d   = (state_q == ACTIVE) && !((x_q == '0) && (y_q == '0));
                state_d = ACTIVE;
                lo_d    = i_hue_lo;
                hi_d    = i_hue_hi;
            end else if (state_q == ACTIVE) begin
                if ((x_q == '0) && (y_q == '0)) begin
                    err_d   = 1'b1;
                    state_d = SYNC;
                end else begin
                    proc = 1'b1;
                end
            end
        end

        cx    = start ? '0 : x_q;
        cy    = start ? '0 : y_q;
        n_cnt = start ? '0 : acc_cnt_q;
        n_hit = start ? 1'b0 : acc_hit_q;
        n_box = acc_box_q;
        if (match) begin
            if (n_cnt != '1) n_cnt = n_cnt + COUNT_W'(1);
            if (!n_hit) begin
                n_box = '{xmin: cx, xmax: cx, ymin: cy, ymax: cy};
            end else begin
                if (cx < n_box.xmin) n_box.xmin = cx;
                if (cx > n_box.xmax) n_box.xmax = cx;
                if (cy < n_box.ymin) n_box.ymin = cy;
                if (cy > n_box.ymax) n_box.ymax = cy;
            end
            n_hit = 1'b1;
        end
        last_px = (cx == X_LAST) && (cy == Y_LAST);

        if (proc) begin
            mask_d = match;
            if (last_px) begin
                bbox_vld_d = 1'b1;
                cnt_d      = n_cnt;
                found_d    = (n_cnt >= COUNT_W'(MIN_PIXELS));
                box_d      = found_d ? n_box : '0;
                acc_cnt_d  = '0;
                acc_box_d  = '0;
                acc_hit_d  = 1'b0;
                x_d        = '0;
                y_d        = '0;
            end else begin
                acc_cnt_d = n_cnt;
                acc_box_d = n_box;
                acc_hit_d = n_hit;
                if (cx == X_LAST) begin
                    x_d = '0;
                    y_d = cy + COORD_W'(1);
                end else begin
                    x_d = cx + COORD_W'(1);
                    y_d = cy;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= SYNC;
            x_q        <= '0;
            y_q        <= '0;
            acc_cnt_q  <= '0;
            acc_box_q  <= '0;
            acc_hit_q  <= 1'b0;
            lo_q       <= '0;
            hi_q       <= '0;
            mask_q     <= 1'b0;
            mask_vld_q <= 1'b0;
            err_q      <= 1'b0;
            bbox_vld_q <= 1'b0;
            cnt_q      <= '0;
            found_q    <= 1'b0;
            box_q      <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            acc_cnt_q  <= acc_cnt_d;
            acc_box_q  <= acc_box_d;
            acc_hit_q  <= acc_hit_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            mask_q     <= mask_d;
            mask_vld_q <= mask_vld_d;
            err_q      <= err_d;
            bbox_vld_q <= bbox_vld_d;
            cnt_q      <= cnt_d;
            found_q    <= found_d;
            box_q      <= box_d;
        end
    end

    assign o_mask       = mask_q;
    assign o_mask_valid = mask_vld_q;
    assign o_err        = err_q;
    assign o_bbox_valid = bbox_vld_q;
    assign o_count      = cnt_q;
    assign o_found      = found_q;
    assign o_xmin       = box_q.xmin;
    assign o_xmax       = box_q.xmax;
    assign o_ymin       = box_q.ymin;
    assign o_ymax       = box_q.ymax;

endmodule

// File: tb/tb_hue_bbox_tracker.sv
// Bench for hue_bbox_tracker: directed scenarios plus random frames against a pixel-list model.
module tb_hue_bbox_tracker;

    localparam int unsigned H    = 8;
    localparam int unsigned V    = 4;
    localparam int unsigned MINP = 2;
    localparam int unsigned NPIX = H * V;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] i_data;
    logic        i_valid, i_sof;
    logic [8:0]  i_hue_lo, i_hue_hi;
    logic        o_mask, o_mask_valid, o_found, o_bbox_valid, o_err;
    logic [9:0]  o_xmin, o_xmax, o_ymin, o_ymax;
    logic [19:0] o_count;

    hue_bbox_tracker #(.H_ACTIVE(H), .V_ACTIVE(V), .MIN_PIXELS(MINP)) dut (
        .i_clk(clk), .i_rst(rst), .i_data(i_data), .i_valid(i_valid), .i_sof(i_sof),
        .i_hue_lo(i_hue_lo), .i_hue_hi(i_hue_hi), .o_mask(o_mask), .o_mask_valid(o_mask_valid),
        .o_xmin(o_xmin), .o_xmax(o_xmax), .o_ymin(o_ymin), .o_ymax(o_ymax),
        .o_count(o_count), .o_found(o_found), .o_bbox_valid(o_bbox_valid), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: frame position as a pixel index, matches kept as coordinate lists.
    bit m_active;
    int m_idx, m_lo, m_hi;
    int hx[$];
    int hy[$];
    int fr[NPIX];
    bit e_m, e_mv, e_err, e_bv, e_found;
    int e_cnt, e_xmin, e_xmax, e_ymin, e_ymax;

    function automatic bit ref_match(input int h, input int lo, input int hi);
        if (h >= 360) return 1'b0;
        if (lo <= hi) return (h >= lo) && (h <= hi);
        return (h >= lo) || (h <= hi);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("mask_valid", 32'(o_mask_valid), 32'(e_mv));
        chk("mask", 32'(o_mask), 32'(e_m));
        chk("err", 32'(o_err), 32'(e_err));
        chk("bbox_valid", 32'(o_bbox_valid), 32'(e_bv));
        chk("count", 32'(o_count), 32'(e_cnt));
        chk("found", 32'(o_found), 32'(e_found));
        chk("xmin", 32'(o_xmin), 32'(e_xmin));
        chk("xmax", 32'(o_xmax), 32'(e_xmax));
        chk("ymin", 32'(o_ymin), 32'(e_ymin));
        chk("ymax", 32'(o_ymax), 32'(e_ymax));
    endtask

    task automatic close_frame();
        e_bv    = 1'b1;
        e_cnt   = hx.size();
        e_found = (e_cnt >= int'(MINP));
        e_xmin  = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0;
        if (e_found) begin
            e_xmin = H; e_xmax = 0; e_ymin = V; e_ymax = 0;
            foreach (hx[k]) begin
                if (hx[k] < e_xmin) e_xmin = hx[k];
                if (hx[k] > e_xmax) e_xmax = hx[k];
                if (hy[k] < e_ymin) e_ymin = hy[k];
                if (hy[k] > e_ymax) e_ymax = hy[k];
            end
        end
        hx.delete();
        hy.delete();
        m_idx = 0;
    endtask

    task automatic step(input int h, input bit sof, input bit v, input int lo, input int hi);
        bit proc = 1'b0;
        e_mv = v; e_m = 1'b0; e_err = 1'b0; e_bv = 1'b0;
        if (v) begin
            if (sof) begin
                if (m_active && m_idx != 0) e_err = 1'b1;
                m_active = 1'b1; m_idx = 0; m_lo = lo; m_hi = hi;
                hx.delete(); hy.delete();
                proc = 1'b1;
            end else if (m_active) begin
                if (m_idx == 0) begin
                    e_err = 1'b1;
                    m_active = 1'b0;
                end else begin
                    proc = 1'b1;
                end
            end
        end
        if (proc) begin
            e_m = ref_match(h, m_lo, m_hi);
            if (e_m) begin
                hx.push_back(m_idx % H);
                hy.push_back(m_idx / H);
            end
            m_idx++;
            if (m_idx == int'(NPIX)) close_frame();
        end
        @(negedge clk);
        i_data = 16'(h); i_sof = sof; i_valid = v;
        i_hue_lo = 9'(lo); i_hue_hi = 9'(hi);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; i_valid = 1'b0; i_sof = 1'b0;
        m_active = 1'b0; m_idx = 0; hx.delete(); hy.delete();
        e_m = 0; e_mv = 0; e_err = 0; e_bv = 0; e_found = 0;
        e_cnt = 0; e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0;
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Non-sof pixels carry a random window to show it is ignored mid-frame.
    task automatic send_frame(input int lo, input int hi, input bit gaps);
        for (int i = 0; i < int'(NPIX); i++) begin
            if (gaps) repeat ($urandom_range(0, 2))
                step($urandom_range(0, 359), 1'($urandom_range(0, 1)), 1'b0,
                     $urandom_range(0, 511), $urandom_range(0, 511));
            if (i == 0) step(fr[i], 1'b1, 1'b1, lo, hi);
            else        step(fr[i], 1'b0, 1'b1, $urandom_range(0, 511), $urandom_range(0, 511));
        end
    endtask

    task automatic send_partial(input int n, input int lo, input int hi);
        for (int i = 0; i < n; i++)
            step($urandom_range(0, 359), i == 0, 1'b1, lo, hi);
    endtask

    task automatic fill_random(input int lo_h, input int hi_h);
        for (int i = 0; i < int'(NPIX); i++) fr[i] = $urandom_range(lo_h, hi_h);
    endtask

    initial begin
        rst = 1'b1; i_data = '0; i_valid = 1'b0; i_sof = 1'b0; i_hue_lo = '0; i_hue_hi = '0;
        do_reset();

        // Basic bounding box.
        for (int i = 0; i < int'(NPIX); i++) fr[i] = 0;
        fr[1*H+2] = 120; fr[1*H+5] = 120; fr[3*H+3] = 120;
        send_frame(100, 140, 1'b0);
        chk("basic_strobe", 32'(o_bbox_valid), 32'd1);
        chk("basic_count", 32'(o_count), 32'd3);
        chk("basic_found", 32'(o_found), 32'd1);
        chk("basic_xmin", 32'(o_xmin), 32'd2);
        chk("basic_xmax", 32'(o_xmax), 32'd5);
        chk("basic_ymin", 32'(o_ymin), 32'd1);
        chk("basic_ymax", 32'(o_ymax), 32'd3);
        step(0, 1'b0, 1'b0, 0, 0);
        chk("basic_hold", 32'(o_count), 32'd3);

        // Wrapping window with out-of-range hue.
        fill_random(20, 340);
        fr[0] = 355; fr[1] = 0; fr[2] = 10; fr[3] = 11; fr[4] = 349; fr[5] = 360;
        send_frame(350, 10, 1'b0);
        chk("wrap_count", 32'(o_count), 32'd3);

        // Single match stays below threshold.
        for (int i = 0; i < int'(NPIX); i++) fr[i] = 0;
        fr[7] = 120;
        send_frame(100, 140, 1'b0);
        chk("below_count", 32'(o_count), 32'd1);
        chk("below_found", 32'(o_found), 32'd0);
        chk("below_xmax", 32'(o_xmax), 32'd0);
        chk("below_ymin", 32'(o_ymin), 32'd0);

        // Early sof after 13 pixels restarts the frame.
        send_partial(13, 0, 359);
        fill_random(0, 359);
        send_frame(50, 200, 1'b0);

        // Valid gaps inside a frame.
        fill_random(0, 359);
        send_frame(90, 270, 1'b1);

        // Missing sof after a completed frame; stray pixels ignored.
        step(120, 1'b0, 1'b1, 0, 359);
        for (int i = 0; i < 5; i++) step(120, 1'b0, 1'b1, 0, 359);
        fill_random(0, 359);
        send_frame(300, 60, 1'b1);

        // Reset mid-frame.
        send_partial(10, 0, 359);
        do_reset();
        step(120, 1'b0, 1'b1, 0, 359);
        fill_random(0, 359);
        send_frame(0, 180, 1'b0);

        // Random frames, including hue values outside 0..359.
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < int'(NPIX); i++)
                fr[i] = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 359);
            send_frame($urandom_range(0, 359), $urandom_range(0, 359), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) send_partial($urandom_range(2, 20), 0, 359);
        end
        fill_random(0, 359);
        send_frame(10, 350, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
